// File: rtl/ws2812_pkg.sv
// Shared WS2812B constants for a 12 MHz system clock: bit timing, latch gap,
// decoder thresholds, GRB colour words and the receive FSM state type.
package ws2812_pkg;

   localparam int WS_T0H_CLKS   = 5;
   localparam int WS_T1H_CLKS   = 10;
   localparam int WS_BIT_CLKS   = 15;
   localparam int WS_RESET_CLKS = 600;

   localparam int WS_MIN_HIGH_CLKS   = 2;
   localparam int WS_BIT_THRESH_CLKS = 8;
   localparam int WS_MAX_HIGH_CLKS   = 13;

   localparam logic [23:0] GRB_GREEN = 24'hFF0000;
   localparam logic [23:0] GRB_RED   = 24'h00FF00;
   localparam logic [23:0] GRB_BLUE  = 24'h0000FF;

   typedef enum logic [1:0] {
      ST_RESYNC,
      ST_IDLE,
      ST_HIGH,
      ST_LOW
   } rx_state_e;

endpackage

// File: rtl/ws2812_rx_decoder_if.sv
// Decoded pixel stream and frame/status strobes leaving the WS2812B receiver.
interface ws2812_rx_decoder_if #(
   parameter int IDX_W = 8
);

   logic [23:0]      pixel_data;
   logic             pixel_valid;
   logic [IDX_W-1:0] pixel_idx;
   logic             frame_done;
   logic [IDX_W-1:0] frame_pixels;
   logic             bit_err;
   logic             in_frame;

   modport master (
      output pixel_data, pixel_valid, pixel_idx,
      output frame_done, frame_pixels, bit_err, in_frame
   );

   modport slave (
      input pixel_data, pixel_valid, pixel_idx,
      input frame_done, frame_pixels, bit_err, in_frame
   );

endinterface

// File: rtl/ws2812_sync_edge.sv
// Two-flop synchroniser for the asynchronous serial line, with single-cycle
// rise/fall pulses derived from the synchronised level.
module ws2812_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic din_sync,
   output logic rise,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = din;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign din_sync = sync_q;
   assign rise     = sync_q & ~prev_q;
   assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812_rx_decoder.sv
// WS2812B receiver: measures high/low pulse widths on the synchronised line,
// assembles 24-bit GRB words and reports frame boundaries and timing errors.
module ws2812_rx_decoder
   import ws2812_pkg::*;
#(
   parameter int MIN_HIGH_CLKS   = WS_MIN_HIGH_CLKS,
   parameter int BIT_THRESH_CLKS = WS_BIT_THRESH_CLKS,
   parameter int MAX_HIGH_CLKS   = WS_MAX_HIGH_CLKS,
   parameter int RESET_CLKS      = WS_RESET_CLKS,
   parameter int IDX_W           = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din,
   ws2812_rx_decoder_if.master  rx
);

   localparam int HC_W = $clog2(MAX_HIGH_CLKS + 2);
   localparam int LC_W = $clog2(RESET_CLKS + 1);

   localparam logic [HC_W-1:0]  HC_MIN  = HC_W'(MIN_HIGH_CLKS);
   localparam logic [HC_W-1:0]  HC_THR  = HC_W'(BIT_THRESH_CLKS);
   localparam logic [HC_W-1:0]  HC_MAX  = HC_W'(MAX_HIGH_CLKS);
   localparam logic [HC_W-1:0]  HC_ONE  = HC_W'(1);
   localparam logic [HC_W-1:0]  HC_SAT  = '1;
   localparam logic [LC_W-1:0]  LC_GAP  = LC_W'(RESET_CLKS);
   localparam logic [LC_W-1:0]  LC_LAST = LC_W'(RESET_CLKS - 1);
   localparam logic [LC_W-1:0]  LC_ONE  = LC_W'(1);
   localparam logic [IDX_W-1:0] IDX_SAT = '1;

   rx_state_e        state_q, state_d;
   logic [HC_W-1:0]  high_cnt_q, high_cnt_d;
   logic [LC_W-1:0]  low_cnt_q, low_cnt_d;
   logic [4:0]       bit_cnt_q, bit_cnt_d;
   logic [22:0]      shift_q, shift_d;
   logic [IDX_W-1:0] idx_cnt_q, idx_cnt_d;
   logic [IDX_W-1:0] frame_cnt_q, frame_cnt_d;

   logic [23:0]      pixel_data_q, pixel_data_d;
   logic             pixel_valid_q, pixel_valid_d;
   logic [IDX_W-1:0] pixel_idx_q, pixel_idx_d;
   logic             frame_done_q, frame_done_d;
   logic [IDX_W-1:0] frame_pixels_q, frame_pixels_d;
   logic             bit_err_q, bit_err_d;
   logic             in_frame_q, in_frame_d;

   logic din_sync, rise, fall;
   logic high_err, bit_accept, bit_val, word_done, gap_hit, resync_done;

   ws2812_sync_edge u_sync (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .din_sync (din_sync),
      .rise     (rise),
      .fall     (fall)
   );

   // Over-long highs abort immediately rather than waiting for the fall.
   assign high_err    = (state_q == ST_HIGH) &&
                        ((high_cnt_q > HC_MAX) || (fall && (high_cnt_q < HC_MIN)));
   assign bit_accept  = (state_q == ST_HIGH) && fall && !high_err;
   assign bit_val     = (high_cnt_q >= HC_THR);
   assign word_done   = bit_accept && (bit_cnt_q == 5'd23);
   assign gap_hit     = (state_q == ST_LOW) && (low_cnt_q == LC_GAP);
   assign resync_done = (state_q == ST_RESYNC) && !din_sync && (low_cnt_q >= LC_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_RESYNC;
         high_cnt_q     <= '0;
         low_cnt_q      <= '0;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         idx_cnt_q      <= '0;
         frame_cnt_q    <= '0;
         pixel_data_q   <= '0;
         pixel_valid_q  <= 1'b0;
         pixel_idx_q    <= '0;
         frame_done_q   <= 1'b0;
         frame_pixels_q <= '0;
         bit_err_q      <= 1'b0;
         in_frame_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         high_cnt_q     <= high_cnt_d;
         low_cnt_q      <= low_cnt_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         idx_cnt_q      <= idx_cnt_d;
         frame_cnt_q    <= frame_cnt_d;
         pixel_data_q   <= pixel_data_d;
         pixel_valid_q  <= pixel_valid_d;
         pixel_idx_q    <= pixel_idx_d;
         frame_done_q   <= frame_done_d;
         frame_pixels_q <= frame_pixels_d;
         bit_err_q      <= bit_err_d;
         in_frame_q     <= in_frame_d;
      end
   end

   // A rise landing exactly on the gap count is lost: the latch gap wins.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESYNC: if (resync_done) state_d = ST_IDLE;
         ST_IDLE:   if (rise) state_d = ST_HIGH;
         ST_HIGH: begin
            if (high_err)  state_d = ST_RESYNC;
            else if (fall) state_d = ST_LOW;
         end
         ST_LOW: begin
            if (gap_hit)   state_d = ST_IDLE;
            else if (rise) state_d = ST_HIGH;
         end
         default: state_d = ST_RESYNC;
      endcase
   end

   always_comb begin
      high_cnt_d     = high_cnt_q;
      low_cnt_d      = low_cnt_q;
      bit_cnt_d      = bit_cnt_q;
      shift_d        = shift_q;
      idx_cnt_d      = idx_cnt_q;
      frame_cnt_d    = frame_cnt_q;
      pixel_data_d   = pixel_data_q;
      pixel_valid_d  = 1'b0;
      pixel_idx_d    = pixel_idx_q;
      frame_done_d   = 1'b0;
      frame_pixels_d = frame_pixels_q;
      bit_err_d      = 1'b0;
      in_frame_d     = in_frame_q;

      case (state_q)
         ST_RESYNC: begin
            if (din_sync || resync_done) low_cnt_d = '0;
            else                         low_cnt_d = low_cnt_q + 1'b1;
         end
         ST_IDLE: begin
            if (rise) begin
               high_cnt_d = HC_ONE;
               in_frame_d = 1'b1;
            end
         end
         ST_HIGH: begin
            if (high_err) begin
               bit_err_d   = 1'b1;
               in_frame_d  = 1'b0;
               bit_cnt_d   = '0;
               idx_cnt_d   = '0;
               frame_cnt_d = '0;
               pixel_idx_d = '0;
               low_cnt_d   = '0;
               high_cnt_d  = '0;
            end else if (bit_accept) begin
               shift_d   = {shift_q[21:0], bit_val};
               low_cnt_d = LC_ONE;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (word_done) begin
                  pixel_valid_d = 1'b1;
                  pixel_data_d  = {shift_q, bit_val};
                  pixel_idx_d   = idx_cnt_q;
                  idx_cnt_d     = idx_cnt_q + 1'b1;
                  bit_cnt_d     = '0;
                  if (frame_cnt_q != IDX_SAT) frame_cnt_d = frame_cnt_q + 1'b1;
               end
            end else if (high_cnt_q != HC_SAT) begin
               high_cnt_d = high_cnt_q + 1'b1;
            end
         end
         ST_LOW: begin
            if (gap_hit) begin
               if (bit_cnt_q != 5'd0) begin
                  bit_err_d = 1'b1;
               end else if (frame_cnt_q != '0) begin
                  frame_done_d   = 1'b1;
                  frame_pixels_d = frame_cnt_q;
               end
               bit_cnt_d   = '0;
               idx_cnt_d   = '0;
               frame_cnt_d = '0;
               pixel_idx_d = '0;
               in_frame_d  = 1'b0;
               low_cnt_d   = '0;
            end else if (rise) begin
               high_cnt_d = HC_ONE;
            end else begin
               low_cnt_d = low_cnt_q + 1'b1;
            end
         end
         default: begin
            low_cnt_d = '0;
         end
      endcase
   end

   assign rx.pixel_data   = pixel_data_q;
   assign rx.pixel_valid  = pixel_valid_q;
   assign rx.pixel_idx    = pixel_idx_q;
   assign rx.frame_done   = frame_done_q;
   assign rx.frame_pixels = frame_pixels_q;
   assign rx.bit_err      = bit_err_q;
   assign rx.in_frame     = in_frame_q;

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Scoreboard bench for the WS2812B receiver: directed pulse trains push
// expected pixel/frame/error events, a monitor pops them as strobes appear.
module tb_ws2812_rx_decoder;
   import ws2812_pkg::*;

   localparam int K_PIX = 0;
   localparam int K_FRM = 1;
   localparam int K_ERR = 2;

   typedef struct {
      int          kind;
      logic [23:0] data;
      int          idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic din;

   int   total;
   int   bad;
   int   expIdx;
   exp_t expQ[$];

   ws2812_rx_decoder_if #(.IDX_W(8)) rx ();

   ws2812_rx_decoder dut (
      .clk (clk),
      .rst (rst),
      .din (din),
      .rx  (rx)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Drive a level for a number of clock cycles.
   task automatic applyStimulus(input logic level, input int clks);
      din = level;
      repeat (clks) @(negedge clk);
   endtask

   task automatic sendRaw(input int highClks, input int lowClks);
      applyStimulus(1'b1, highClks);
      applyStimulus(1'b0, lowClks);
   endtask

   task automatic sendBit(input logic b);
      if (b) sendRaw(WS_T1H_CLKS, WS_BIT_CLKS - WS_T1H_CLKS);
      else   sendRaw(WS_T0H_CLKS, WS_BIT_CLKS - WS_T0H_CLKS);
   endtask

   task automatic sendBits(input logic [23:0] w, input int n);
      for (int i = 23; i > 23 - n; i--) sendBit(w[i]);
   endtask

   task automatic sendPixel(input logic [23:0] w, input bit expectIt);
      if (expectIt) begin
         expQ.push_back('{K_PIX, w, expIdx});
         expIdx++;
      end
      sendBits(w, 24);
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while (expQ.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain", expQ.size(), 0);
   endtask

   task automatic endFrame(input int npix);
      if (npix > 0) expQ.push_back('{K_FRM, 24'h0, npix});
      applyStimulus(1'b0, 650);
      expIdx = 0;
      waitDrain(100);
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (rx.pixel_valid || rx.frame_done || rx.bit_err)) begin
            checkOutput("strobe_overlap", 32'(rx.pixel_valid) + 32'(rx.frame_done) + 32'(rx.bit_err), 1);
            checkOutput("event_pending", expQ.size() != 0, 1);
            if (expQ.size() != 0) begin
               e = expQ.pop_front();
               if (rx.pixel_valid) begin
                  checkOutput("pix_kind", K_PIX, e.kind);
                  checkOutput("pix_data", rx.pixel_data, e.data);
                  checkOutput("pix_idx", rx.pixel_idx, e.idx);
               end else if (rx.frame_done) begin
                  checkOutput("frame_kind", K_FRM, e.kind);
                  checkOutput("frame_pixels", rx.frame_pixels, e.idx);
               end else begin
                  checkOutput("err_kind", K_ERR, e.kind);
               end
            end
         end
      end
   end

   initial begin
      logic [23:0] w;
      total  = 0;
      bad    = 0;
      expIdx = 0;
      rst    = 1'b1;
      din    = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("rst_pixel_valid", rx.pixel_valid, 0);
      checkOutput("rst_pixel_data", rx.pixel_data, 0);
      checkOutput("rst_pixel_idx", rx.pixel_idx, 0);
      checkOutput("rst_frame_done", rx.frame_done, 0);
      checkOutput("rst_frame_pixels", rx.frame_pixels, 0);
      checkOutput("rst_bit_err", rx.bit_err, 0);
      checkOutput("rst_in_frame", rx.in_frame, 0);
      rst = 1'b0;
      applyStimulus(1'b0, 650);

      $display("[TB] basic GRB frame");
      sendPixel(24'hFF0000, 1);
      checkOutput("in_frame_mid", rx.in_frame, 1);
      sendPixel(24'h00FF00, 1);
      sendPixel(24'h0000FF, 1);
      endFrame(3);
      checkOutput("in_frame_after", rx.in_frame, 0);

      $display("[TB] loopback two frames");
      for (int f = 0; f < 2; f++) begin
         sendPixel(GRB_GREEN, 1);
         sendPixel(GRB_RED, 1);
         sendPixel(GRB_BLUE, 1);
         endFrame(3);
      end

      $display("[TB] threshold 7/8 clks");
      expQ.push_back('{K_PIX, 24'h000FFF, 0});
      for (int i = 0; i < 12; i++) sendRaw(7, 8);
      for (int i = 0; i < 12; i++) sendRaw(8, 7);
      endFrame(1);

      $display("[TB] 599-clk low continues frame");
      w = 24'h00FF00;
      expQ.push_back('{K_PIX, w, 0});
      for (int i = 23; i >= 0; i--) begin
         if (i == 12) sendRaw(w[i] ? 10 : 5, 599);
         else         sendBit(w[i]);
      end
      checkOutput("in_frame_599", rx.in_frame, 1);
      expIdx = 1;
      sendPixel(24'h0000FF, 1);
      endFrame(2);

      $display("[TB] 600-clk low ends frame");
      w = 24'hFF0000;
      expQ.push_back('{K_PIX, w, 0});
      sendBits(w, 23);
      expQ.push_back('{K_FRM, 24'h0, 1});
      sendRaw(5, 600);
      sendRaw(10, 650);
      waitDrain(100);
      checkOutput("in_frame_600", rx.in_frame, 0);

      $display("[TB] 1-clk glitch");
      sendBits(24'hFF0000, 5);
      expQ.push_back('{K_ERR, 24'h0, 0});
      sendRaw(1, 10);
      sendBits(24'hAAAAAA, 24);
      applyStimulus(1'b0, 650);
      waitDrain(100);
      checkOutput("in_frame_glitch", rx.in_frame, 0);
      sendPixel(24'hFF0000, 1);
      endFrame(1);

      $display("[TB] 14-clk high");
      sendBits(24'h00FF00, 7);
      expQ.push_back('{K_ERR, 24'h0, 0});
      sendRaw(14, 5);
      sendBits(24'h555555, 24);
      applyStimulus(1'b0, 650);
      waitDrain(100);
      sendPixel(24'h0000FF, 1);
      endFrame(1);

      $display("[TB] partial word at gap");
      sendPixel(24'h0000FF, 1);
      sendPixel(24'h00FF00, 1);
      sendBits(24'hFF0000, 12);
      checkOutput("pix_idx_mid", rx.pixel_idx, 1);
      expQ.push_back('{K_ERR, 24'h0, 0});
      endFrame(0);
      checkOutput("pix_idx_after_gap", rx.pixel_idx, 0);
      checkOutput("in_frame_partial", rx.in_frame, 0);

      $display("[TB] reset mid-frame with line high");
      sendBits(24'hFFFFFF, 10);
      din = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("in_frame_post_rst", rx.in_frame, 0);
      checkOutput("pix_idx_post_rst", rx.pixel_idx, 0);
      sendPixel(24'h0000FF, 0);
      applyStimulus(1'b0, 650);
      sendPixel(24'hFF0000, 1);
      endFrame(1);

      waitDrain(1000);
      checkOutput("queue_empty", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
